// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider.
// Holds the FSM state encodings and width-generic helpers for the signed
// minimum constant and two's-complement negation. Helpers work on a
// MAX_W-bit container; callers pass their operand width and truncate the
// result with an explicit cast.
package seq_divider_pkg;

    localparam int unsigned MAX_W = 128;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_CALC = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef logic [2:0] state_t;

    // Most negative two's-complement value of a w-bit word
    function automatic logic [MAX_W-1:0] signed_min(input int unsigned w);
        return MAX_W'(1) << (w - 1);
    endfunction

    // Two's-complement negation of a w-bit word
    function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x,
                                                  input int unsigned      w);
        logic [MAX_W-1:0] mask;
        mask = (MAX_W'(1) << w) - MAX_W'(1);
        return (~x + MAX_W'(1)) & mask;
    endfunction

endpackage

// File: rtl/seq_divider_p_if.sv
// Operand/result handshake bundle for seq_divider_p.
// master: issues operands (in_valid, is_signed, dividend, divisor) and
//         accepts results (out_ready).
// slave : the divider; returns in_ready, out_valid, quotient, remainder,
//         div_by_zero, overflow.
interface seq_divider_p_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output in_valid, is_signed, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, is_signed, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider_p_lzc.sv
// div_lzc: combinational leading-one detector.
// Ports:
//   x_i   : WIDTH-bit input word
//   msb_o : bit index of the most significant 1 in x_i (0 when x_i is 0);
//           purely combinational
module div_lzc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]         x_i,
    output logic [$clog2(WIDTH)-1:0] msb_o
);
    localparam int unsigned POS_W = $clog2(WIDTH);

    // Scan upward so the highest set bit wins
    always_comb begin
        msb_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x_i[i]) begin
                msb_o = POS_W'(i);
            end
        end
    end
endmodule

// File: rtl/seq_divider_p.sv
// seq_divider_p: multi-cycle radix-2 restoring divider, signed/unsigned,
// valid/ready on both sides, one operation in flight.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   bus_if : seq_divider_p_if.slave (operands in, results + flags out)
// Optional build macro DIV_EARLY_TERM_EN: skips the leading-zero iterations
// using two leading-one detectors; without it every operation runs WIDTH
// iterations.
module seq_divider_p
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_p_if.slave bus_if
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;           // latched dividend
    logic [WIDTH-1:0]   b_q, b_d;           // latched divisor
    logic               sgn_q, sgn_d;       // latched signed mode
    logic [WIDTH-1:0]   sh_q, sh_d;         // dividend bits still to bring in
    logic [WIDTH-1:0]   dvs_q, dvs_d;       // |divisor|
    logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0]   quo_q, quo_d;       // quotient magnitude
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dz_q, dz_d;         // pending divide-by-zero
    logic               ov_q, ov_d;         // pending signed overflow
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic [WIDTH-1:0]   abs_a_c, abs_b_c;
    logic               zero_b_c, ovf_case_c;
    logic [WIDTH:0]     part_c;
    logic               ge_c;
    logic [CNT_W-1:0]   n_c;
    logic [WIDTH-1:0]   rem0_c, sh0_c;

    // Operand magnitudes and special-case detection from the latched operands
    always_comb begin
        abs_a_c    = (sgn_q && a_q[WIDTH-1]) ? WIDTH'(twos_neg(MAX_W'(a_q), WIDTH)) : a_q;
        abs_b_c    = (sgn_q && b_q[WIDTH-1]) ? WIDTH'(twos_neg(MAX_W'(b_q), WIDTH)) : b_q;
        zero_b_c   = (b_q == '0);
        ovf_case_c = sgn_q && (a_q == WIDTH'(signed_min(WIDTH))) && (b_q == '1);
    end

    // One restoring step: shift in next dividend bit, compare against |divisor|
    always_comb begin
        part_c = {rem_q, sh_q[WIDTH-1]};
        ge_c   = (part_c >= {1'b0, dvs_q});
    end

`ifdef DIV_EARLY_TERM_EN
    localparam int unsigned POS_W = $clog2(WIDTH);
    logic [POS_W-1:0] msb_a_c, msb_b_c;

    div_lzc #(.WIDTH(WIDTH)) u_lzc_a (.x_i(abs_a_c), .msb_o(msb_a_c));
    div_lzc #(.WIDTH(WIDTH)) u_lzc_b (.x_i(abs_b_c), .msb_o(msb_b_c));
`endif

    // Iteration count and initial datapath load.
    // With early termination the partial remainder is preloaded with the
    // dividend bits above the divisor's alignment point (always < |divisor|),
    // which is the same as aligning the divisor under the dividend's leading
    // one; the remaining N bits sit left-justified in the shift register.
    always_comb begin
        n_c    = CNT_W'(WIDTH);
        rem0_c = '0;
        sh0_c  = abs_a_c;
`ifdef DIV_EARLY_TERM_EN
        if (abs_a_c >= abs_b_c) begin
            n_c    = CNT_W'(msb_a_c) - CNT_W'(msb_b_c) + CNT_W'(1);
            rem0_c = abs_a_c >> n_c;
            sh0_c  = abs_a_c << (CNT_W'(WIDTH) - n_c);
        end else begin
            n_c    = '0;
            rem0_c = abs_a_c;
            sh0_c  = '0;
        end
`endif
    end

    // Next-state and datapath/output next values
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        sh_d        = sh_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        dz_d        = dz_q;
        ov_d        = ov_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.in_valid && in_ready_q) begin
                    a_d        = bus_if.dividend;
                    b_d        = bus_if.divisor;
                    sgn_d      = bus_if.is_signed;
                    dbz_d      = 1'b0;
                    ovf_d      = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = ST_PREP;
                end
            end
            ST_PREP: begin
                dz_d   = zero_b_c;
                ov_d   = ovf_case_c && !zero_b_c;
                qneg_d = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                rneg_d = sgn_q && a_q[WIDTH-1];
                dvs_d  = abs_b_c;
                rem_d  = rem0_c;
                sh_d   = sh0_c;
                quo_d  = '0;
                cnt_d  = n_c;
                if (zero_b_c || ovf_case_c || (n_c == '0)) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                sh_d  = sh_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (ge_c) begin
                    rem_d = WIDTH'(part_c - {1'b0, dvs_q});
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = part_c[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                quotient_d  = qneg_q ? WIDTH'(twos_neg(MAX_W'(quo_q), WIDTH)) : quo_q;
                remainder_d = rneg_q ? WIDTH'(twos_neg(MAX_W'(rem_q), WIDTH)) : rem_q;
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = a_q;
                    dbz_d       = 1'b1;
                end else if (ov_q) begin
                    quotient_d  = WIDTH'(signed_min(WIDTH));
                    remainder_d = '0;
                    ovf_d       = 1'b1;
                end
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus_if.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            sh_q        <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            sh_q        <= sh_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            dz_q        <= dz_d;
            ov_q        <= ov_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus_if.in_ready    = in_ready_q;
    assign bus_if.out_valid   = out_valid_q;
    assign bus_if.quotient    = quotient_q;
    assign bus_if.remainder   = remainder_q;
    assign bus_if.div_by_zero = dbz_q;
    assign bus_if.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider_p.sv
// Self-checking bench for seq_divider_p (WIDTH=32): table of directed
// vectors, model-checked random vectors, output hold, input scrambling
// while busy, and asynchronous reset mid-operation and in DONE.
module tb_seq_divider_p;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    vec_t tbl[16];

    seq_divider_p_if #(.WIDTH(32)) bus_if ();

    seq_divider_p #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

`ifdef DIV_EARLY_TERM_EN
    function automatic int msb32(input logic [31:0] x);
        int m;
        m = 0;
        for (int i = 0; i < 32; i++) if (x[i]) m = i;
        return m;
    endfunction
`endif

    // Expected edges from accept to out_valid
    function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] aa;
        logic [31:0] bb;
        if (b == 32'd0) return 2;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        aa = (s && a[31]) ? (~a + 32'd1) : a;
        bb = (s && b[31]) ? (~b + 32'd1) : b;
`ifdef DIV_EARLY_TERM_EN
        if (aa < bb) return 2;
        return msb32(aa) - msb32(bb) + 3;
`else
        if (aa == bb) return 34;
        return 34;
`endif
    endfunction

    // Reference result using the simulator's own division operators
    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        e.lat = exp_lat(s, a, b);
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q  = 32'h8000_0000;
            e.r  = 32'd0;
            e.ov = 1'b1;
        end else if (s) begin
            e.q = 32'($signed(a) / $signed(b));
            e.r = 32'($signed(a) % $signed(b));
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Issue one operation; the expectation goes on the scoreboard at issue
    // and is popped when the result appears.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input int hold);
        exp_t got;
        int   cyc;
        sb_q.push_back(e);
        @(negedge clk);
        check("in_ready_idle", 32'(bus_if.in_ready), 32'd1);
        bus_if.in_valid  = 1'b1;
        bus_if.is_signed = s;
        bus_if.dividend  = a;
        bus_if.divisor   = b;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        check("in_ready_busy", 32'(bus_if.in_ready), 32'd0);
        check("dz_cleared_on_accept", 32'(bus_if.div_by_zero), 32'd0);
        check("ov_cleared_on_accept", 32'(bus_if.overflow), 32'd0);
        cyc = 0;
        while (!bus_if.out_valid && cyc < 200) begin
            bus_if.dividend  = $urandom();
            bus_if.divisor   = $urandom();
            bus_if.is_signed = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            cyc++;
        end
        got = sb_q.pop_front();
        if (!bus_if.out_valid) begin
            check("result_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", 32'(cyc), 32'(got.lat));
        check("quotient", bus_if.quotient, got.q);
        check("remainder", bus_if.remainder, got.r);
        check("div_by_zero", 32'(bus_if.div_by_zero), 32'(got.dz));
        check("overflow", 32'(bus_if.overflow), 32'(got.ov));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bus_if.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus_if.in_ready), 32'd0);
            check("hold_quotient", bus_if.quotient, got.q);
            check("hold_remainder", bus_if.remainder, got.r);
            check("hold_dz", 32'(bus_if.div_by_zero), 32'(got.dz));
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        check("valid_drop_after_hs", 32'(bus_if.out_valid), 32'd0);
        check("in_ready_after_hs", 32'(bus_if.in_ready), 32'd1);
    endtask

    // Start 100/7 unsigned and hit rst mid-cycle after wait_cyc edges or,
    // with wait_cyc < 0, once the result is waiting in DONE.
    task automatic reset_during(input int wait_cyc, input logic [31:0] prev_q);
        int cyc;
        @(negedge clk);
        bus_if.in_valid  = 1'b1;
        bus_if.is_signed = 1'b0;
        bus_if.dividend  = 32'd100;
        bus_if.divisor   = 32'd7;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        cyc = 0;
        if (wait_cyc >= 0) begin
            repeat (wait_cyc) @(posedge clk);
            #1;
            check("pre_rst_quotient_held", bus_if.quotient, prev_q);
        end else begin
            while (!bus_if.out_valid && cyc < 200) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check("pre_rst_valid", 32'(bus_if.out_valid), 32'd1);
            check("pre_rst_quotient", bus_if.quotient, 32'd14);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_async_quotient", bus_if.quotient, 32'd0);
        check("rst_async_remainder", bus_if.remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("rst_valid_stays_low", 32'(bus_if.out_valid), 32'd0);
    endtask

    initial begin
        exp_t        e;
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;

        checks = 0;
        errors = 0;
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.is_signed = 1'b0;
        bus_if.dividend  = 32'd0;
        bus_if.divisor   = 32'd0;
        bus_if.out_ready = 1'b0;

        //          s     dividend       divisor        quotient       remainder      dz    ov
        tbl[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 1'b1};
        tbl[5]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 1'b0};
        tbl[8]  = '{1'b1, 32'd0,         32'd0,         32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0};
        tbl[9]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'd5,         32'd1000,      32'd0,         32'd5,         1'b0, 1'b0};
        tbl[11] = '{1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0, 1'b0};
        tbl[12] = '{1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0,         1'b0, 1'b0};
        tbl[13] = '{1'b1, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b0};
        tbl[15] = '{1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0, 1'b0};

        #23;
        check("reset_valid", 32'(bus_if.out_valid), 32'd0);
        check("reset_quotient", bus_if.quotient, 32'd0);
        check("reset_remainder", bus_if.remainder, 32'd0);
        check("reset_dz", 32'(bus_if.div_by_zero), 32'd0);
        check("reset_ov", 32'(bus_if.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_in_ready", 32'(bus_if.in_ready), 32'd1);

        // Directed table; first entry also holds the result for 5 cycles
        for (int i = 0; i < 16; i++) begin
            e.q   = tbl[i].q;
            e.r   = tbl[i].r;
            e.dz  = tbl[i].dz;
            e.ov  = tbl[i].ov;
            e.lat = exp_lat(tbl[i].s, tbl[i].a, tbl[i].b);
            do_op(tbl[i].s, tbl[i].a, tbl[i].b, e, (i == 0) ? 5 : 1);
        end

        // Random operands against the reference model
        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom();
            rb = (i < 4) ? 32'($urandom_range(1, 5000)) : $urandom();
            do_op(rs, ra, rb, model(rs, ra, rb), 0);
        end

        // Known result in the output register before the mid-CALC reset
        do_op(1'b0, 32'd1000, 32'd7, model(1'b0, 32'd1000, 32'd7), 0);
        reset_during(3, 32'd142);
        reset_during(-1, 32'd0);

        // Recovery after reset
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, model(1'b1, 32'hFFFF_FF9C, 32'd7), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
